// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Holds the loader state encoding and the default instruction-memory address width.
package imem_boot_loader_pkg;

  localparam int PC_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HI    = 3'd1,
    ST_LO    = 3'd2,
    ST_WRITE = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/imem_boot_loader_byte_to_word_packer.sv
// Packs two stream bytes into one big-endian 16-bit word.
// Ports: i_cap_hi/i_cap_lo capture i_byte; o_word is the word, o_word_valid pulses after the low byte.
module byte_to_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cap_hi,
  input  logic        i_cap_lo,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_word,
  output logic        o_word_valid
);

  logic [15:0] r_word;
  logic        r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_cap_lo;
      if (i_cap_hi) r_word[15:8] <= i_byte;
      if (i_cap_lo) r_word[7:0]  <= i_byte;
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_valid;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams bytes into instruction memory from a base address and holds the core in reset until loaded.
// Ports: start/load_base/load_len, byte stream handshake, imem write port, core_rst, busy, done, err.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int PC_WIDTH      = PC_W,
  parameter int CORE_RST_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [PC_WIDTH-1:0] load_base,
  input  logic [PC_WIDTH:0]   load_len,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  output logic                byte_ready,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_write_en,
  output logic [15:0]         imem_write_data,
  output logic                core_rst,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int HW =
    (CORE_RST_HOLD > 1) ? $clog2(CORE_RST_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(CORE_RST_HOLD - 1);
  localparam logic [PC_WIDTH:0] REM_ONE =
    (PC_WIDTH+1)'(1);

  state_t              r_state;
  state_t              w_nxt;
  logic [PC_WIDTH-1:0] r_addr;
  logic [PC_WIDTH:0]   r_rem;
  logic [HW-1:0]       r_hold;
  logic                r_err;

  logic w_xfer;
  logic w_start_ok;
  logic w_hold_end;
  logic w_cap_hi;
  logic w_cap_lo;

  assign w_start_ok = start &&
    (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_xfer = byte_valid && byte_ready;
  assign w_cap_hi = w_xfer && (r_state == ST_HI);
  assign w_cap_lo = w_xfer && (r_state == ST_LO);
  assign w_hold_end = (r_state == ST_HOLD) &&
    (r_hold == HOLD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_ok)
          w_nxt = (load_len == '0) ? ST_HOLD : ST_HI;
      end
      ST_HI:    if (w_xfer) w_nxt = ST_LO;
      ST_LO:    if (w_xfer) w_nxt = ST_WRITE;
      ST_WRITE: w_nxt = (r_rem == REM_ONE) ? ST_HOLD : ST_HI;
      ST_HOLD:  if (w_hold_end) w_nxt = ST_DONE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
      r_rem  <= '0;
      r_hold <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_err  <= 1'b0;
        r_hold <= '0;
        if (load_len != '0) begin
          r_addr <= load_base;
          r_rem  <= load_len;
        end
      end
      if (r_state == ST_WRITE) begin
        r_addr <= r_addr + PC_WIDTH'(1);
        r_rem  <= r_rem - REM_ONE;
        // wrap with words still to come overwrites low memory
        if (r_addr == '1 && r_rem > REM_ONE) r_err <= 1'b1;
      end
      if (r_state == ST_HOLD)
        r_hold <= w_hold_end ? '0 : r_hold + HW'(1);
    end
  end

  byte_to_word_packer u_pack (
    .clk          (clk),
    .rst_n        (rst),
    .i_cap_hi     (w_cap_hi),
    .i_cap_lo     (w_cap_lo),
    .i_byte       (byte_in),
    .o_word       (imem_write_data),
    .o_word_valid (imem_write_en)
  );

  assign byte_ready = (r_state == ST_HI) ||
                      (r_state == ST_LO);
  assign busy = (r_state == ST_HI) || (r_state == ST_LO) ||
                (r_state == ST_WRITE) || (r_state == ST_HOLD);
  assign core_rst  = (r_state != ST_DONE);
  assign done      = (r_state == ST_DONE);
  assign err       = r_err;
  assign imem_addr = r_addr;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: directed scenarios plus randomized loads
// checked against a list-of-writes reference model.
module tb_imem_boot_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] load_base = '0;
  logic [AW:0]   load_len = '0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready, imem_write_en, core_rst;
  logic          busy, done, err;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_write_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_strobe = -1;
  int fall_cyc = -1;
  logic prev_crst = 1'b1;
  logic [23:0] wq[$];
  logic [23:0] eq[$];
  logic [7:0]  bq[$];

  imem_boot_loader #(.PC_WIDTH(AW), .CORE_RST_HOLD(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .load_base(load_base), .load_len(load_len),
    .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .imem_addr(imem_addr),
    .imem_write_en(imem_write_en),
    .imem_write_data(imem_write_data),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_write_en) begin
      wq.push_back({imem_addr, imem_write_data});
      last_strobe = cyc;
    end
    if (prev_crst && !core_rst) fall_cyc = cyc;
    prev_crst = core_rst;
  end

  // expected writes: word i lands at (base+i) mod depth
  task automatic build_expect(input int b, input int l,
                              output bit e_err);
    int a;
    eq.delete();
    for (int i = 0; i < l; i++) begin
      a = (b + i) % (1 << AW);
      eq.push_back({a[7:0], bq[2*i], bq[2*i+1]});
    end
    e_err = (l > 0) && (b + l > (1 << AW));
  endtask

  task automatic start_load(input logic [AW-1:0] b,
                            input logic [AW:0] l,
                            output int sc);
    wq.delete();
    last_strobe = -1;
    fall_cyc = -1;
    start = 1'b1;
    load_base = b;
    load_len = l;
    @(posedge clk); #1;
    sc = cyc;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall,
                           output bit to);
    bit got;
    int k;
    logic x;
    got = 0;
    k = 0;
    byte_valid = 1'b0;
    repeat (stall) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_in = b;
    while (!got && k < 200) begin
      @(negedge clk); x = byte_ready;
      @(posedge clk); #1;
      got = x;
      k++;
    end
    byte_valid = 1'b0;
    byte_in = 8'($urandom);
    to = !got;
  endtask

  task automatic wait_done(output bit to);
    int k;
    bit d;
    k = 0;
    d = 0;
    while (!d && k < 300) begin
      @(negedge clk); d = done; k++;
    end
    @(posedge clk); #1;
    to = !d;
  endtask

  task automatic do_load(input int b, input int l, input int smax,
                         output int sc, output bit to);
    bit t;
    to = 0;
    start_load(AW'(b), (AW+1)'(l), sc);
    for (int k = 0; k < 2*l; k++) begin
      send_byte(bq[k], int'($urandom_range(0, smax)), t);
      to |= t;
    end
    wait_done(t);
    to |= t;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({byte_ready, imem_write_en, core_rst, busy, done, err}
        !== 6'b001000) begin
      n_bad++;
      $display("FAIL reset_ctl got %b want 001000",
        {byte_ready, imem_write_en, core_rst, busy, done, err});
    end
    n_cmp++;
    if (imem_addr !== '0) begin
      n_bad++;
      $display("FAIL reset_addr got %h want 00", imem_addr);
    end
    n_cmp++;
    if (imem_write_data !== '0) begin
      n_bad++;
      $display("FAIL reset_data got %h want 0000", imem_write_data);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal;
    bit to, ee;
    int sc;
    bq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    build_expect(0, 3, ee);
    do_load(0, 3, 0, sc, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL nominal timeout"); end
    n_cmp++;
    if (wq.size() != eq.size()) begin
      n_bad++;
      $display("FAIL nominal count got %0d want %0d", wq.size(), eq.size());
    end
    foreach (eq[i]) if (i < wq.size()) begin
      n_cmp++;
      if (wq[i] !== eq[i]) begin
        n_bad++;
        $display("FAIL nominal w%0d got %h want %h", i, wq[i], eq[i]);
      end
    end
    n_cmp++;
    if (fall_cyc - last_strobe != 5) begin
      n_bad++;
      $display("FAIL nominal latency got %0d want 5", fall_cyc - last_strobe);
    end
    n_cmp++;
    if ({done, err, core_rst, busy} !== {1'b1, ee, 2'b00}) begin
      n_bad++;
      $display("FAIL nominal status got %b want %b",
        {done, err, core_rst, busy}, {1'b1, ee, 2'b00});
    end
  endtask

  task automatic test_stall;
    bit to, t, ee;
    int sc;
    for (int k = 0; k < 4; k++) bq[k] = 8'($urandom);
    build_expect(128, 2, ee);
    start_load(8'd128, 9'd2, sc);
    to = 0;
    for (int w = 0; w < 2; w++) begin
      send_byte(bq[2*w], (w == 0) ? 0 : 7, t);
      to |= t;
      for (int s = 0; s < 7; s++) begin
        @(negedge clk);
        n_cmp++;
        if (byte_ready !== 1'b1 || imem_write_en !== 1'b0) begin
          n_bad++;
          $display("FAIL stall_ready got %b%b want 10",
            byte_ready, imem_write_en);
        end
      end
      @(posedge clk); #1;
      send_byte(bq[2*w+1], 0, t);
      to |= t;
    end
    wait_done(t);
    to |= t;
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL stall timeout"); end
    n_cmp++;
    if (wq.size() != eq.size()) begin
      n_bad++;
      $display("FAIL stall count got %0d want %0d", wq.size(), eq.size());
    end
    foreach (eq[i]) if (i < wq.size()) begin
      n_cmp++;
      if (wq[i] !== eq[i]) begin
        n_bad++;
        $display("FAIL stall w%0d got %h want %h", i, wq[i], eq[i]);
      end
    end
  endtask

  task automatic test_wrap;
    bit to, ee;
    int sc;
    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    build_expect(255, 2, ee);
    do_load(255, 2, 1, sc, to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL wrap timeout"); end
    n_cmp++;
    if (wq.size() != eq.size()) begin
      n_bad++;
      $display("FAIL wrap count got %0d want %0d", wq.size(), eq.size());
    end
    foreach (eq[i]) if (i < wq.size()) begin
      n_cmp++;
      if (wq[i] !== eq[i]) begin
        n_bad++;
        $display("FAIL wrap w%0d got %h want %h", i, wq[i], eq[i]);
      end
    end
    n_cmp++;
    if ({done, err} !== {1'b1, ee}) begin
      n_bad++;
      $display("FAIL wrap status got %b want %b", {done, err}, {1'b1, ee});
    end
  endtask

  task automatic test_zero;
    bit to;
    int sc;
    start_load(8'd7, 9'd0, sc);
    @(negedge clk);
    n_cmp++;
    if ({core_rst, busy, done} !== 3'b110) begin
      n_bad++;
      $display("FAIL zero_hold got %b want 110", {core_rst, busy, done});
    end
    @(posedge clk); #1;
    wait_done(to);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL zero timeout"); end
    n_cmp++;
    if (wq.size() != 0) begin
      n_bad++;
      $display("FAIL zero strobes got %0d want 0", wq.size());
    end
    n_cmp++;
    if (fall_cyc - sc != 4) begin
      n_bad++;
      $display("FAIL zero hold_len got %0d want 4", fall_cyc - sc);
    end
    n_cmp++;
    if ({done, err, core_rst} !== 3'b100) begin
      n_bad++;
      $display("FAIL zero status got %b want 100", {done, err, core_rst});
    end
  endtask

  task automatic test_reset_mid;
    bit to, t, ee;
    int sc;
    start_load(8'd0, 9'd3, sc);
    send_byte(8'h11, 0, t);
    send_byte(8'h22, 0, t);
    @(posedge clk); #1;
    send_byte(8'h33, 0, t);
    #3 rst = 1'b0;
    #1;
    n_cmp++;
    if ({byte_ready, imem_write_en, core_rst, busy, done, err}
        !== 6'b001000 || imem_addr !== '0 || imem_write_data !== '0) begin
      n_bad++;
      $display("FAIL midrst got %b/%h/%h want 001000/00/0000",
        {byte_ready, imem_write_en, core_rst, busy, done, err},
        imem_addr, imem_write_data);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    bq = '{8'h00, 8'h01};
    build_expect(0, 1, ee);
    do_load(0, 1, 0, sc, to);
    n_cmp++;
    if (to || wq.size() != 1) begin
      n_bad++;
      $display("FAIL midrst_reload count got %0d want 1", wq.size());
    end else begin
      n_cmp++;
      if (wq[0] !== eq[0]) begin
        n_bad++;
        $display("FAIL midrst_reload got %h want %h", wq[0], eq[0]);
      end
    end
  endtask

  task automatic test_start_busy;
    bit to, t, ee;
    int sc;
    for (int k = 0; k < 4; k++) bq[k] = 8'($urandom);
    build_expect(16, 2, ee);
    start_load(8'd16, 9'd2, sc);
    send_byte(bq[0], 0, to);
    start = 1'b1;
    load_base = 8'd200;
    load_len = 9'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 4; k++) begin
      send_byte(bq[k], 0, t);
      to |= t;
    end
    wait_done(t);
    to |= t;
    n_cmp++;
    if (to || wq.size() != eq.size()) begin
      n_bad++;
      $display("FAIL busy_start count got %0d want %0d", wq.size(), eq.size());
    end
    foreach (eq[i]) if (i < wq.size()) begin
      n_cmp++;
      if (wq[i] !== eq[i]) begin
        n_bad++;
        $display("FAIL busy_start w%0d got %h want %h", i, wq[i], eq[i]);
      end
    end
  endtask

  task automatic test_random;
    bit to, ee;
    int sc, b, l;
    for (int it = 0; it < 20; it++) begin
      b = (it % 3 == 0) ? int'($urandom_range(250, 255))
                        : int'($urandom_range(0, 255));
      l = int'($urandom_range(0, 6));
      bq.delete();
      for (int k = 0; k < 2*l; k++) bq.push_back(8'($urandom));
      build_expect(b, l, ee);
      do_load(b, l, 3, sc, to);
      n_cmp++;
      if (to || wq.size() != eq.size()) begin
        n_bad++;
        $display("FAIL rand%0d count got %0d want %0d", it, wq.size(), eq.size());
      end
      foreach (eq[i]) if (i < wq.size()) begin
        n_cmp++;
        if (wq[i] !== eq[i]) begin
          n_bad++;
          $display("FAIL rand%0d w%0d got %h want %h", it, i, wq[i], eq[i]);
        end
      end
      n_cmp++;
      if ({done, err, core_rst} !== {1'b1, ee, 1'b0}) begin
        n_bad++;
        $display("FAIL rand%0d status got %b want %b", it,
          {done, err, core_rst}, {1'b1, ee, 1'b0});
      end
      n_cmp++;
      if ((l > 0 && fall_cyc - last_strobe != 5) ||
          (l == 0 && fall_cyc - sc != 4)) begin
        n_bad++;
        $display("FAIL rand%0d latency fall %0d strobe %0d start %0d",
          it, fall_cyc, last_strobe, sc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_wrap();
    test_zero();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Upstream feeder for the 16-bit instruction memory write port. Accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. Writes them into consecutive instruction-memory addresses from a programmable base, and holds the mips_16 core in reset until the image is fully loaded. Lets the system boot the core from a host or UART link instead of preloading the ROM.

Parameters:
PC_WIDTH, 8, instruction-memory address width; memory depth is 2**PC_WIDTH words.
CORE_RST_HOLD, 4, cycles the core reset stays asserted after the last write.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; begins a load using load_base and load_len. Sampled only in IDLE or DONE.
load_base  in  PC_WIDTH  first instruction-memory word address.
load_len  in  PC_WIDTH+1  number of 16-bit words to load; 0 is legal.
byte_in  in  8  stream data byte.
byte_valid  in  1  byte_in is valid.
byte_ready  out  1  loader accepts a byte this cycle (transfer = byte_valid & byte_ready).
imem_addr  out  PC_WIDTH  write address; the top level muxes it onto the memory address while busy.
imem_write_en  out  1  one-cycle write strobe.
imem_write_data  out  16  assembled instruction word.
core_rst  out  1  active-high reset to the core.
busy  out  1  a load is in progress.
done  out  1  load finished; level, cleared by the next start.
err  out  1  address wrap detected; sticky until the next start.

Behaviour:
- Reset values, while rst is low: state IDLE; byte_ready=0; imem_write_en=0; imem_addr=0; imem_write_data=0; core_rst=1; busy=0; done=0; err=0; word and hold counters 0.
- States: IDLE, HI, LO, WRITE, HOLD, DONE.
- IDLE/DONE + start:
  - load_len!=0: latch base into imem_addr, latch len into the remaining counter, clear done and err, go to HI. busy=1, core_rst=1.
  - load_len==0: go directly to HOLD.
- HI: byte_ready=1. On transfer, byte_in goes to imem_write_data[15:8]; go to LO.
- LO: byte_ready=1. On transfer, byte_in goes to [7:0]; go to WRITE.
- WRITE: byte_ready=0. imem_write_en=1 for exactly this cycle, with addr and data stable. On the next edge:
  - imem_addr increments, wrapping mod 2**PC_WIDTH.
  - remaining counter decrements.
  - If the increment wraps past the top address while remaining>1, set err=1. The load continues.
  - remaining reaches 0: go to HOLD; otherwise go to HI.
- Handshake timing: byte_ready is combinational from state only, never from byte_valid. Minimum 3 cycles per word. byte_valid low stalls indefinitely in HI/LO with no timeout.
- HOLD: core_rst=1, busy=1. The hold counter counts CORE_RST_HOLD cycles, then go to DONE.
- DONE: core_rst=0, busy=0, done=1. Bytes presented here are not accepted (byte_ready=0).
- start while busy is ignored.
- Async reset mid-load aborts immediately. Partially written memory is not cleaned up, and the core stays in reset.
- Latency: last LO transfer -> write strobe 1 cycle later -> core_rst falls CORE_RST_HOLD+1 cycles after the strobe.

Decomposition:
- Shared package holds the state encoding (3-bit localparams IDLE..DONE) and PC_WIDTH, shared with the core and instruction memory.
- One natural sub-module, byte_to_word_packer: HI/LO capture plus word-valid pulse. The address counter and FSM stay in the top.

Test Plan:
1. Nominal load. Stimulus: base=0, len=3, bytes 12 34 56 78 9A BC presented back-to-back. Response: writes 0x1234@0, 0x5678@1, 0x9ABC@2, each strobe exactly one cycle; core_rst falls 5 cycles after the last strobe; done=1, err=0.
2. Stalled stream. Stimulus: base=128, len=2, byte_valid toggled low for 7 cycles between bytes. Response: writes land at 128 and 129 with correct data; no extra strobes; byte_ready stays high while waiting.
3. Wrap. Stimulus: base=255, len=2, bytes AA BB CC DD. Response: 0xAABB@255, 0xCCDD@0, err=1, done=1.
4. Zero length. Stimulus: start with len=0. Response: no write strobe; core_rst held for 4 cycles then released; done=1.
5. Reset mid-load. Stimulus: rst low after 1 of 3 words. Response: all outputs return to reset values asynchronously; core_rst=1. A new start with base=0, len=1, bytes 00 01 writes 0x0001@0 correctly.
6. Start while busy. Stimulus: second start pulse during LO with a different base. Response: ignored; original addresses and count are preserved.
